// File: rtl/sram_arbiter.sv
// Shared audio SRAM port arbiter: recorder writes take priority, DSP/player reads
// are forced through after STARVE_MAX consecutive write grants.
module sram_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int WR_CYCLES  = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic              i_AUD_BCLK,
   input  logic              i_rst_n,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR      = 3'd1;
   localparam logic [2:0] WR_TURN = 3'd2;
   localparam logic [2:0] RD_ADDR = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;

   localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_force;
   logic              dq_oe;

   assign rd_force = i_rd_req && (starve_q == STARVE_TOP);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      wr_ack_d   = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      case (state_q)
         IDLE: begin
            // The ack/valid cycle is blanked so a still-held request is not served twice.
            if (!wr_ack_q && !rd_valid_q) begin
               if (i_wr_req && !rd_force) begin
                  state_d = WR;
                  addr_d  = i_wr_addr;
                  data_d  = i_wr_data;
                  cnt_d   = '0;
                  if (!i_rd_req)
                     starve_d = '0;
                  else if (starve_q != STARVE_TOP)
                     starve_d = starve_q + SW'(1);
               end else if (i_rd_req) begin
                  state_d  = RD_ADDR;
                  addr_d   = i_rd_addr;
                  starve_d = '0;
               end else begin
                  starve_d = '0;
               end
            end
         end
         WR: begin
            if (cnt_q == WR_LAST)
               state_d = WR_TURN;
            else
               cnt_d = cnt_q + CW'(1);
         end
         WR_TURN: begin
            state_d  = IDLE;
            wr_ack_d = 1'b1;
         end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            state_d    = IDLE;
            rd_valid_d = 1'b1;
            rd_data_d  = io_SRAM_DQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         starve_q   <= '0;
         wr_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         wr_ack_q   <= wr_ack_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Pins decode from registered state only; DQ is driven through the WE_N-high hold cycle.
   assign dq_oe       = (state_q == WR) || (state_q == WR_TURN);
   assign io_SRAM_DQ  = dq_oe ? data_q : {DATA_W{1'bz}};
   assign o_SRAM_ADDR = (state_q == IDLE) ? '0 : addr_q;
   assign o_SRAM_WE_N = (state_q != WR);
   assign o_SRAM_OE_N = !((state_q == RD_ADDR) || (state_q == RD_DATA));
   assign o_SRAM_CE_N = 1'b0;
   assign o_SRAM_LB_N = 1'b0;
   assign o_SRAM_UB_N = 1'b0;
   assign o_busy      = (state_q != IDLE);
   assign o_wr_ack    = wr_ack_q;
   assign o_rd_valid  = rd_valid_q;
   assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM model and an ack/valid scoreboard.
module tb_sram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        wr_req, rd_req;
   logic [19:0] wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic        wr_ack, rd_valid, busy;
   logic [15:0] rd_data;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        we_n, oe_n, ce_n, lb_n, ub_n;

   typedef struct {
      bit          is_wr;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WR_CYCLES(2), .STARVE_MAX(8)) dut (
      .i_AUD_BCLK (clk),
      .i_rst_n    (rst_n),
      .i_wr_req   (wr_req),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_wr_ack   (wr_ack),
      .i_rd_req   (rd_req),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data),
      .o_rd_valid (rd_valid),
      .o_busy     (busy),
      .o_SRAM_ADDR(sram_addr),
      .io_SRAM_DQ (sram_dq),
      .o_SRAM_WE_N(we_n),
      .o_SRAM_OE_N(oe_n),
      .o_SRAM_CE_N(ce_n),
      .o_SRAM_LB_N(lb_n),
      .o_SRAM_UB_N(ub_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: drives the bus only while OE_N is low and WE_N is high.
   logic [15:0] mem [0:255];
   assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
   always @(posedge clk) if (!we_n) mem[sram_addr[7:0]] <= sram_dq;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input bit is_wr, input logic [15:0] d);
      exp_t e;
      e.is_wr = is_wr;
      e.data  = d;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input int bound);
      int n;
      n = 0;
      while (wr_ack !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("ack_wait", {31'd0, wr_ack}, 32'd1);
   endtask

   task automatic wait_valid(input int bound);
      int n;
      n = 0;
      while (rd_valid !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("valid_wait", {31'd0, rd_valid}, 32'd1);
   endtask

   // Monitor: pops the scoreboard on every ack/valid and checks bus safety every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         chk("bus_conflict", {31'd0, we_n | oe_n}, 32'd1);
         if (wr_ack) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack actual=1 expected=0 at %0t", $time);
            end else begin
               e = sb.pop_front();
               chk("ack_order_is_wr", {31'd0, wr_ack}, {31'd0, e.is_wr});
            end
         end
         if (rd_valid) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=1 expected=0 at %0t", $time);
            end else begin
               e = sb.pop_front();
               chk("valid_order_is_rd", {31'd0, e.is_wr}, 32'd0);
               chk("rd_data", {16'd0, rd_data}, {16'd0, e.data});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   int  acks;
   int  n;
   bit  rd_started;

   initial begin
      rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      cyc(3);
      chk("rst_we_n", {31'd0, we_n}, 32'd1);
      chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
      chk("rst_ce_lb_ub", {29'd0, ce_n, lb_n, ub_n}, 32'd0);
      chk("rst_addr", {12'd0, sram_addr}, 32'd0);
      chk("rst_outs", {28'd0, wr_ack, rd_valid, busy, dut.dq_oe}, 32'd0);
      chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
      chk("rst_starve", {28'd0, dut.starve_q}, 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Single write; input changes after the grant must be ignored
      wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 16'hBEEF; push(1'b1, 16'h0);
      cyc(1);
      chk("wr_c1_we_n", {31'd0, we_n}, 32'd0);
      chk("wr_c1_oe_n", {31'd0, oe_n}, 32'd1);
      chk("wr_c1_addr", {12'd0, sram_addr}, 32'h10);
      chk("wr_c1_busy", {31'd0, busy}, 32'd1);
      wr_data = 16'h1234; wr_addr = 20'h00099;
      cyc(1);
      chk("wr_c2_we_n", {31'd0, we_n}, 32'd0);
      cyc(1);
      chk("wr_c3_we_n", {31'd0, we_n}, 32'd1);
      chk("wr_c3_dq_hold", {16'd0, sram_dq}, 32'hBEEF);
      chk("wr_c3_addr", {12'd0, sram_addr}, 32'h10);
      cyc(1);
      chk("wr_c4_ack", {31'd0, wr_ack}, 32'd1);
      chk("wr_c4_dq_z", {31'd0, dut.dq_oe}, 32'd0);
      wr_req = 1'b0;
      cyc(2);

      // Readback, holding rd_req one cycle past valid (blanking)
      rd_req = 1'b1; rd_addr = 20'h00010; push(1'b0, 16'hBEEF);
      cyc(1);
      chk("rd_c1_oe_n", {31'd0, oe_n}, 32'd0);
      chk("rd_c1_we_n", {31'd0, we_n}, 32'd1);
      cyc(1);
      chk("rd_c2_oe_n", {31'd0, oe_n}, 32'd0);
      cyc(1);
      chk("rd_c3_valid", {31'd0, rd_valid}, 32'd1);
      chk("rd_c3_oe_n", {31'd0, oe_n}, 32'd1);
      cyc(1);
      chk("blank_busy", {31'd0, busy}, 32'd0);
      chk("blank_valid", {31'd0, rd_valid}, 32'd0);
      rd_req = 1'b0;
      cyc(2);
      chk("rd_data_hold", {16'd0, rd_data}, 32'hBEEF);

      // Simultaneous requests: write first, blank IDLE, then read
      wr_req = 1'b1; wr_addr = 20'h00020; wr_data = 16'hA5A5;
      rd_req = 1'b1; rd_addr = 20'h00020;
      push(1'b1, 16'h0); push(1'b0, 16'hA5A5);
      cyc(1);
      chk("sim_first_is_wr", {30'd0, we_n, oe_n}, 32'd1);
      wait_ack(10);
      wr_req = 1'b0;
      cyc(1);
      chk("sim_idle_gap", {31'd0, busy}, 32'd0);
      cyc(1);
      chk("sim_rd_oe_n", {31'd0, oe_n}, 32'd0);
      wait_valid(10);
      rd_req = 1'b0;
      cyc(2);

      // Starvation: 8 write acks, forced read, then writes resume
      wr_req = 1'b1; wr_addr = 20'h00040; wr_data = 16'h4000;
      rd_req = 1'b1; rd_addr = 20'h00020;
      for (int i = 0; i < 8; i++) push(1'b1, 16'h0);
      push(1'b0, 16'hA5A5);
      push(1'b1, 16'h0); push(1'b1, 16'h0);
      acks = 0; n = 0; rd_started = 1'b0;
      while (acks < 10 && n < 300) begin
         cyc(1);
         n++;
         if (!oe_n && !rd_started) begin
            rd_started = 1'b1;
            chk("starve_cleared", {28'd0, dut.starve_q}, 32'd0);
            chk("acks_before_read", acks, 32'd8);
         end
         if (wr_ack) begin
            acks++;
            wr_addr = 20'h00040 + 20'(acks);
            wr_data = 16'h4000 + 16'(acks);
            if (acks == 10) wr_req = 1'b0;
         end
         if (rd_valid) rd_req = 1'b0;
      end
      chk("starve_acks", acks, 32'd10);
      chk("starve_read_seen", {31'd0, rd_started}, 32'd1);
      cyc(2);

      // Reset in the first WR cycle drops the write
      wr_req = 1'b1; wr_addr = 20'h00050; wr_data = 16'h7777;
      cyc(1);
      chk("mid_wr_we_n", {31'd0, we_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we_n", {31'd0, we_n}, 32'd1);
      chk("rst_mid_dq_z", {31'd0, dut.dq_oe}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_ack", {31'd0, wr_ack}, 32'd0);
      wr_req = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(4);
      wr_req = 1'b1; push(1'b1, 16'h0);
      wait_ack(10);
      wr_req = 1'b0;
      cyc(2);
      rd_req = 1'b1; rd_addr = 20'h00050; push(1'b0, 16'h7777);
      wait_valid(10);
      rd_req = 1'b0;
      cyc(3);
      chk("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Owns the single shared audio SRAM port and arbitrates between two requesters: the recorder write path and the DSP/player read path.
- Replaces direct state-based muxing of SRAM address, data and control.
- Sequences the SRAM pins cycle by cycle, including WE_N pulse, data hold and bus turnaround.
- Uses write-priority arbitration with a read anti-starvation limit, and returns an ack to the writer or valid read data to the reader.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
WR_CYCLES, 2, number of cycles WE_N is held low per write (>=1)
STARVE_MAX, 8, consecutive writes granted while a read waits before the read is forced

Ports:
i_AUD_BCLK  in  1  clock
i_rst_n  in  1  reset
i_wr_req  in  1  write request (level, held until o_wr_ack)
i_wr_addr  in  ADDR_W  write address
i_wr_data  in  DATA_W  write data
o_wr_ack  out  1  one-cycle pulse: write completed
i_rd_req  in  1  read request (level, held until o_rd_valid)
i_rd_addr  in  ADDR_W  read address
o_rd_data  out  DATA_W  read data, registered
o_rd_valid  out  1  one-cycle pulse: o_rd_data valid
o_busy  out  1  high whenever state != IDLE
o_SRAM_ADDR  out  ADDR_W  SRAM address
io_SRAM_DQ  inout  DATA_W  SRAM data bus
o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_CE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  SRAM strobes

Behaviour:
- Interface (already decided): reset i_rst_n, asynchronous, active-low; clock i_AUD_BCLK.
- Reset / idle values:
  - state IDLE; o_SRAM_WE_N=1, o_SRAM_OE_N=1; o_SRAM_CE_N=o_SRAM_LB_N=o_SRAM_UB_N=0.
  - o_SRAM_ADDR=0; io_SRAM_DQ=Z.
  - o_wr_ack=0, o_rd_valid=0, o_rd_data=0, o_busy=0, starve counter=0.
- States: IDLE, WR, WR_TURN, RD_ADDR, RD_DATA. All are registered, and all pin outputs are decoded from registered state and latched fields.
- Grant (IDLE only):
  - i_wr_req wins unless i_rd_req=1 and starve counter==STARVE_MAX.
  - Address and data are latched at the grant edge; later changes on the inputs are ignored.
- Blanking: in the IDLE cycle where o_wr_ack or o_rd_valid is high, requests are not sampled. This prevents re-serving a request still held high.
- Write (grant edge at end of cycle N):
  - Cycles N+1..N+WR_CYCLES: state WR, WE_N=0, OE_N=1, DQ driven with latched data, ADDR = latched address.
  - Cycle N+WR_CYCLES+1: state WR_TURN, WE_N=1, DQ and ADDR still driven (data hold).
  - Cycle N+WR_CYCLES+2: state IDLE, o_wr_ack=1, DQ=Z.
- Read (grant at end of cycle N):
  - Cycle N+1: RD_ADDR, ADDR = latched address, OE_N=0, DQ=Z.
  - Cycle N+2: RD_DATA, same pins; io_SRAM_DQ is captured into o_rd_data at the end of this cycle.
  - Cycle N+3: IDLE, o_rd_valid=1, OE_N=1. o_rd_data holds its value until the next read capture.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each write grant while i_rd_req=1.
  - Clears on a read grant, and clears in any sampled IDLE cycle with i_rd_req=0.
- Bus safety: io_SRAM_DQ is driven only in WR and WR_TURN, so WE_N=0 and OE_N=0 are never both asserted.
- Reset mid-transaction: all outputs return to idle values immediately (async). The in-flight transaction is dropped with no ack or valid, and the requester must re-request.
- Address widths: no wrap or arithmetic inside the block; addresses pass through unchanged.

Test Plan:
- Single write, WR_CYCLES=2: wr_req with addr=0x00010, data=0xBEEF at cycle 0 → WE_N low in cycles 1-2, high in cycle 3 with DQ=0xBEEF still driven, o_wr_ack in cycle 4, DQ=Z in cycle 4.
- Readback: after the write above, rd_req with addr=0x00010 (SRAM model) → OE_N low in cycles 1-2, o_rd_valid in cycle 3 with o_rd_data=0xBEEF; WE_N stays 1 throughout.
- Simultaneous: wr_req and rd_req asserted together in the same cycle → write serviced first, a blank IDLE cycle follows the ack, then the read is granted; exactly one ack and one valid are produced.
- Starvation, STARVE_MAX=8: wr_req held continuously and rd_req held → exactly 8 write acks, then a read grant, then writes resume; the counter is checked at 0 after the read grant.
- Reset mid-write: i_rst_n low in cycle 1 of WR → WE_N=1 and DQ=Z within the same cycle, no o_wr_ack, o_busy=0; after reset, a new request is serviced normally.
- Blanking: requester holds rd_req one cycle past o_rd_valid → no second read is granted in that cycle.
